dac8551_ctrl: RTL and testbench

//  Setpoint front-end sitting directly upstream of dac8551 (SPI shifter).

---
 rtl/dac8551_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dac8551_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac8551_ctrl.sv
// Setpoint front-end for the dac8551 SPI shifter: captures code/power-down
// targets at any rate (latest wins), applies an optional slew limit and
// issues 24-bit words through the i_wr / i_wr_data / o_busy handshake.
module dac8551_ctrl #(
    parameter logic [15:0] INIT_CODE   = 16'h8000,
    parameter bit          INIT_WRITE  = 1'b1,
    parameter int unsigned MIN_GAP     = 4,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_set,
    input  logic [15:0] i_set_code,
    input  logic [1:0]  i_set_pd,
    input  logic [15:0] i_slew,
    output logic        o_dac_wr,
    output logic [23:0] o_dac_wr_data,
    input  logic        i_dac_busy,
    output logic [15:0] o_code,
    output logic [1:0]  o_pd,
    output logic        o_settled,
    output logic        o_err_ack
);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StXfer,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        final_q, final_d;     // in-flight word reaches the target
    logic [15:0] tcode_q, tcode_d;
    logic [1:0]  tpd_q, tpd_d;
    logic [15:0] code_q, code_d;
    logic [1:0]  pd_q, pd_d;
    logic        wr_q, wr_d;
    logic [23:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic [16:0] diff;
    logic [16:0] mag;
    logic        down;
    logic [15:0] step_code;
    logic [23:0] next_word;
    logic        next_final;

    // Next word from target and current code, with slew limiting.
    always_comb begin
        diff      = {1'b0, tcode_q} - {1'b0, code_q};
        down      = diff[16];
        mag       = down ? (17'd0 - diff) : diff;
        step_code = tcode_q;
        if (i_slew != 16'd0 && mag > {1'b0, i_slew}) begin
            // |d| > slew guarantees the step stays strictly inside 0..FFFF
            step_code = down ? (code_q - i_slew) : (code_q + i_slew);
        end
        if (tpd_q != 2'b00) begin
            next_word  = {6'b0, tpd_q, code_q};
            next_final = 1'b1;
        end else begin
            next_word  = {6'b0, 2'b00, step_code};
            next_final = (step_code == tcode_q);
        end
    end

    // Handshake FSM next-state, target capture and output updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        final_d   = final_q;
        tcode_d   = tcode_q;
        tpd_d     = tpd_q;
        code_d    = code_q;
        pd_d      = pd_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        err_d     = err_q;

        if (i_set) begin
            tcode_d = i_set_code;
            tpd_d   = i_set_pd;
        end

        unique case (state_q)
            StIdle: begin
                if (pending_q && !i_dac_busy) begin
                    wr_d      = 1'b1;
                    wdata_d   = next_word;
                    final_d   = next_final;
                    pending_d = 1'b0;
                    cnt_d     = 16'd0;
                    state_d   = StAck;
                end
            end
            StAck: begin
                if (i_dac_busy) begin
                    state_d = StXfer;
                end else if (32'(cnt_q) + 32'd1 >= ACK_TIMEOUT) begin
                    err_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = StGap;
                    if (!final_q) pending_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StXfer: begin
                if (!i_dac_busy) begin
                    code_d  = wdata_q[15:0];
                    pd_d    = wdata_q[17:16];
                    cnt_d   = 16'd0;
                    state_d = StGap;
                    if (!final_q) pending_d = 1'b1;
                end
            end
            StGap: begin
                if (32'(cnt_q) + 32'd1 >= MIN_GAP) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A capture always wins over the clear that accompanies an issue.
        if (i_set) pending_d = 1'b1;
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StGap;
            cnt_q     <= 16'd0;
            pending_q <= INIT_WRITE;
            final_q   <= 1'b1;
            tcode_q   <= INIT_CODE;
            tpd_q     <= 2'b00;
            code_q    <= INIT_CODE;
            pd_q      <= 2'b00;
            wr_q      <= 1'b0;
            wdata_q   <= 24'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            final_q   <= final_d;
            tcode_q   <= tcode_d;
            tpd_q     <= tpd_d;
            code_q    <= code_d;
            pd_q      <= pd_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    // Output mapping.
    always_comb begin
        o_dac_wr      = wr_q;
        o_dac_wr_data = wdata_q;
        o_code        = code_q;
        o_pd          = pd_q;
        o_err_ack     = err_q;
        o_settled     = (state_q == StIdle) && (code_q == tcode_q) && (pd_q == tpd_q);
    end

endmodule

// File: tb/tb_dac8551_ctrl.sv
// Directed bench for dac8551_ctrl with a behavioural busy responder.
module tb_dac8551_ctrl;

    localparam int XferLen = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set = 1'b0;
    logic [15:0] set_code = 16'd0;
    logic [1:0]  set_pd = 2'b00;
    logic [15:0] slew = 16'd0;
    logic        wr;
    logic [23:0] wr_data;
    logic        busy = 1'b0;
    logic [15:0] code;
    logic [1:0]  pd;
    logic        settled;
    logic        err_ack;

    logic        busy_dis = 1'b0;
    int          bcnt = 0;
    logic [23:0] words[$];

    int checks = 0;
    int errors = 0;

    dac8551_ctrl #(
        .INIT_CODE  (16'h8000),
        .INIT_WRITE (1'b1),
        .MIN_GAP    (4),
        .ACK_TIMEOUT(8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_set        (set),
        .i_set_code   (set_code),
        .i_set_pd     (set_pd),
        .i_slew       (slew),
        .o_dac_wr     (wr),
        .o_dac_wr_data(wr_data),
        .i_dac_busy   (busy),
        .o_code       (code),
        .o_pd         (pd),
        .o_settled    (settled),
        .o_err_ack    (err_ack)
    );

    always #5 clk = ~clk;

    // Stand-in for the SPI shifter: log each accepted word, hold busy for XferLen cycles.
    always @(posedge clk) begin
        if (rst || busy_dis) begin
            busy <= 1'b0;
            bcnt <= 0;
        end else if (busy) begin
            if (bcnt == 0) busy <= 1'b0;
            else bcnt <= bcnt - 1;
        end else if (wr) begin
            busy <= 1'b1;
            bcnt <= XferLen - 1;
            words.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_target(input logic [15:0] c, input logic [1:0] p);
        set      = 1'b1;
        set_code = c;
        set_pd   = p;
        @(negedge clk);
        set = 1'b0;
    endtask

    // Wait for 20 consecutive cycles with no write and no busy.
    task automatic wait_quiet(input string tag);
        int q = 0;
        int n = 0;
        while (q < 20 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!busy && !wr) q++;
            else q = 0;
        end
        check(tag, 32'(q >= 20), 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd1);
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        while (!wr && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(wr), 32'd1);
    endtask

    task automatic wait_words(input int cnt, input string tag);
        int n = 0;
        while (words.size() < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(words.size()), 32'(cnt));
    endtask

    initial begin
        // 1. reset values and the automatic initial write
        repeat (3) @(negedge clk);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_data", 32'(wr_data), 32'h0);
        check("rst_code", 32'(code), 32'h8000);
        check("rst_pd", 32'(pd), 32'd0);
        check("rst_err", 32'(err_ack), 32'd0);
        check("rst_settled", 32'(settled), 32'd0);
        rst = 1'b0;
        wait_quiet("init_quiet");
        check("init_nwords", 32'(words.size()), 32'd1);
        check("init_word", 32'(words[0]), 32'h008000);
        check("init_code", 32'(code), 32'h8000);
        check("init_settled", 32'(settled), 32'd1);

        // 2. unlimited slew, single word, 2-cycle issue latency
        words.delete();
        slew     = 16'd0;
        set      = 1'b1;
        set_code = 16'h1234;
        set_pd   = 2'b00;
        @(negedge clk);
        set = 1'b0;
        check("lat_wr_c1", 32'(wr), 32'd0);
        @(negedge clk);
        check("lat_wr_c2", 32'(wr), 32'd1);
        check("lat_data", 32'(wr_data), 32'h001234);
        wait_quiet("t2_quiet");
        check("t2_nwords", 32'(words.size()), 32'd1);
        check("t2_word", 32'(words[0]), 32'h001234);
        check("t2_code", 32'(code), 32'h1234);
        check("t2_settled", 32'(settled), 32'd1);

        // 3. slew-limited ramp 0000 -> A000 in steps of 4000, clamped last step
        set_target(16'h0000, 2'b00);
        wait_quiet("t3_pre_quiet");
        check("t3_pre_code", 32'(code), 32'h0000);
        words.delete();
        slew = 16'h4000;
        set_target(16'hA000, 2'b00);
        wait_words(3, "t3_three");
        check("t3_mid_code", 32'(code), 32'h8000);
        check("t3_mid_settled", 32'(settled), 32'd0);
        wait_quiet("t3_quiet");
        check("t3_nwords", 32'(words.size()), 32'd3);
        check("t3_w0", 32'(words[0]), 32'h004000);
        check("t3_w1", 32'(words[1]), 32'h008000);
        check("t3_w2", 32'(words[2]), 32'h00A000);
        check("t3_code", 32'(code), 32'hA000);
        check("t3_settled", 32'(settled), 32'd1);

        // 4. burst of strobes during a transfer coalesces to one word
        slew = 16'd0;
        words.delete();
        set_target(16'h0700, 2'b00);
        wait_busy("t4_busy");
        for (int i = 1; i <= 5; i++) begin
            set      = 1'b1;
            set_code = 16'(i);
            set_pd   = 2'b00;
            @(negedge clk);
        end
        set = 1'b0;
        wait_quiet("t4_quiet");
        check("t4_nwords", 32'(words.size()), 32'd2);
        check("t4_w0", 32'(words[0]), 32'h000700);
        check("t4_w1", 32'(words[1]), 32'h000005);
        check("t4_code", 32'(code), 32'h0005);

        // 5. power-down keeps the code, then ramp to FFFF without wrapping
        set_target(16'h0100, 2'b00);
        wait_quiet("t5_pre_quiet");
        words.delete();
        slew = 16'h8000;
        set_target(16'hFFFF, 2'b11);
        wait_quiet("t5_pd_quiet");
        check("t5_pd_nwords", 32'(words.size()), 32'd1);
        check("t5_pd_word", 32'(words[0]), 32'h030100);
        check("t5_pd_pd", 32'(pd), 32'd3);
        check("t5_pd_code", 32'(code), 32'h0100);
        check("t5_pd_settled", 32'(settled), 32'd0);
        set_target(16'hFFFF, 2'b00);
        wait_quiet("t5_ramp_quiet");
        check("t5_nwords", 32'(words.size()), 32'd3);
        check("t5_w1", 32'(words[1]), 32'h008100);
        check("t5_w2", 32'(words[2]), 32'h00FFFF);
        check("t5_pd", 32'(pd), 32'd0);
        check("t5_code", 32'(code), 32'hFFFF);
        check("t5_settled", 32'(settled), 32'd1);

        // refresh: same value while idle still produces one write
        words.delete();
        set_target(16'hFFFF, 2'b00);
        wait_quiet("refresh_quiet");
        check("refresh_nwords", 32'(words.size()), 32'd1);
        check("refresh_word", 32'(words[0]), 32'h00FFFF);

        // 6. busy never rises: timeout after exactly 8 cycles in the ack wait
        words.delete();
        busy_dis = 1'b1;
        slew     = 16'd0;
        set_target(16'h1234, 2'b00);
        wait_wr("t6_wr");
        repeat (7) @(negedge clk);
        check("t6_err_early", 32'(err_ack), 32'd0);
        @(negedge clk);
        check("t6_err", 32'(err_ack), 32'd1);
        repeat (10) @(negedge clk);
        check("t6_code", 32'(code), 32'hFFFF);
        check("t6_nwords", 32'(words.size()), 32'd0);
        check("t6_err_sticky", 32'(err_ack), 32'd1);

        // reset in the middle of a transfer
        busy_dis = 1'b0;
        set_target(16'h2222, 2'b00);
        wait_busy("t6b_busy");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wr", 32'(wr), 32'd0);
        check("mid_rst_data", 32'(wr_data), 32'h0);
        check("mid_rst_code", 32'(code), 32'h8000);
        check("mid_rst_pd", 32'(pd), 32'd0);
        check("mid_rst_err", 32'(err_ack), 32'd0);
        check("mid_rst_settled", 32'(settled), 32'd0);
        rst = 1'b0;
        words.delete();
        wait_quiet("post_rst_quiet");
        check("post_rst_word", 32'(words[0]), 32'h008000);
        check("post_rst_settled", 32'(settled), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
